// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// The optional halt-on-zero-instruction feature is selected by FETCH_HALT_ON_ZERO_EN.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        RESP  = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_e;

    localparam int LINE_BEATS       = 8;
    localparam int INSTS_PER_LINE   = 16;
    localparam int LINE_OFFSET_BITS = 6;
    localparam int BEAT_BITS        = 3;
    localparam int SLOT_BITS        = 4;

    // Sysbus tag fields for a memory line read.
    localparam logic       SYSBUS_READ   = 1'b1;
    localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;

    function automatic logic [63:0] line_base(input logic [63:0] addr);
        return {addr[63:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/fetch_line_buffer.sv
// One cache line of fetched instructions: 8 x 64-bit beats written by the bus,
// read back as 16 x 32-bit instruction slots.
module fetch_line_buffer
    import fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [BEAT_BITS-1:0] wr_beat,
    input  logic [63:0]          wr_data,
    input  logic [SLOT_BITS-1:0] rd_slot,
    output logic [31:0]          rd_data
);

    logic [63:0] mem_q [LINE_BEATS];
    logic [63:0] rd_beat;

    // NOTE: the storage has no reset; every slot is written by a full burst
    // before the sequencer is allowed to read it, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_beat] <= wr_data;
        end
    end

    // Low half of a beat is the even instruction, high half the odd one.
    always_comb begin
        rd_beat = mem_q[rd_slot[SLOT_BITS-1:1]];
        rd_data = rd_slot[0] ? rd_beat[63:32] : rd_beat[31:0];
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Line-at-a-time instruction fetch: request a 64-byte line on Sysbus, collect
// 8 beats, then hand instructions to the decoder one per cycle.
// Optional FETCH_HALT_ON_ZERO_EN stops fetch on an all-zero instruction word.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               entry,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic                      bus_respack,
    output logic                      inst_valid,
    input  logic                      inst_ready,
    output logic [31:0]               inst_data,
    output logic [63:0]               inst_pc,
    output logic                      halted
);

    localparam logic [BUS_TAG_WIDTH-1:0] REQ_TAG =
        {SYSBUS_READ, SYSBUS_MEMORY, {(BUS_TAG_WIDTH-5){1'b0}}};
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(LINE_BEATS - 1);
    localparam logic [SLOT_BITS-1:0] LAST_SLOT = SLOT_BITS'(INSTS_PER_LINE - 1);

    state_e               state_q, state_d;
    logic [63:0]          pc_q, pc_d;
    logic [BEAT_BITS-1:0] beat_cnt_q, beat_cnt_d;
    // Low for the first cycle out of reset so the bus sees no request or ack yet.
    logic                 armed_q, armed_d;

    logic                 buf_wr_en;
    logic [31:0]          buf_rd_data;
    logic                 zero_inst;

    fetch_line_buffer u_line_buffer (
        .clk     (clk),
        .wr_en   (buf_wr_en),
        .wr_beat (beat_cnt_q),
        .wr_data (bus_resp[63:0]),
        .rd_slot (pc_q[LINE_OFFSET_BITS-1:2]),
        .rd_data (buf_rd_data)
    );

`ifdef FETCH_HALT_ON_ZERO_EN
    assign zero_inst = (buf_rd_data == 32'h0);
`else
    assign zero_inst = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= REQ;
            pc_q       <= entry;
            beat_cnt_q <= '0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            beat_cnt_q <= beat_cnt_d;
            armed_q    <= armed_d;
        end
    end

    // NOTE: every signal written below gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        beat_cnt_d  = beat_cnt_q;
        armed_d     = 1'b1;
        buf_wr_en   = 1'b0;
        bus_reqcyc  = 1'b0;
        inst_valid  = 1'b0;
        // Beats are always consumed; only RESP stores them, elsewhere they drop.
        bus_respack = bus_respcyc & armed_q & ~reset;

        unique case (state_q)
            REQ: begin
                bus_reqcyc = armed_q;
                if (armed_q && bus_reqack) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus_respcyc && armed_q) begin
                    buf_wr_en = 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        state_d    = DRAIN;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (zero_inst) begin
                    state_d = HALT;
                end else begin
                    inst_valid = 1'b1;
                    if (inst_ready) begin
                        pc_d = pc_q + 64'd4;
                        if (pc_q[LINE_OFFSET_BITS-1:2] == LAST_SLOT) begin
                            state_d = REQ;
                        end
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    assign bus_req    = BUS_DATA_WIDTH'(line_base(pc_q));
    assign bus_reqtag = REQ_TAG;
    assign inst_data  = buf_rd_data;
    assign inst_pc    = pc_q;
    assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a small Sysbus memory model feeds lines
// and a scoreboard of expected (pc, instruction) pairs checks the decoder side.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] entry;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic        bus_respack;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        halted;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] zero_addr = '1;
    logic        zero_stop = 1'b0;

    fetch_sequencer #(
        .BUS_DATA_WIDTH (64),
        .BUS_TAG_WIDTH  (13)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .entry       (entry),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_respack (bus_respack),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected end before 500000ns");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] inst_word(input logic [63:0] addr, input logic [7:0] salt);
        if (addr == zero_addr) return 32'h0;
        return {8'hA5 ^ salt, addr[23:0]};
    endfunction

    function automatic logic [63:0] beat_data(input logic [63:0] line, input int k, input logic [7:0] salt);
        logic [63:0] a;
        a = line + 64'(8 * k);
        return {inst_word(a + 64'd4, salt), inst_word(a, salt)};
    endfunction

    task automatic push_inst(input logic [63:0] pc, input logic [31:0] w);
        exp_t e;
`ifdef FETCH_HALT_ON_ZERO_EN
        if (w == 32'h0) zero_stop = 1'b1;
`endif
        if (!zero_stop) begin
            e.pc   = pc;
            e.data = w;
            sb.push_back(e);
        end
    endtask

    task automatic do_reset(input logic [63:0] entry_v);
        @(negedge clk);
        reset       = 1'b1;
        entry       = entry_v;
        bus_reqack  = 1'b0;
        inst_ready  = 1'b0;
        bus_respcyc = 1'b1;
        bus_resp    = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        #1;
        check("rst_reqcyc", bus_reqcyc, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_respack", bus_respack, 0);
        check("rst_pc", inst_pc, entry_v);
        @(negedge clk);
        reset       = 1'b0;
        bus_respcyc = 1'b0;
        #1;
        check("rel_reqcyc", bus_reqcyc, 0);
        @(negedge clk);
        check("rise_reqcyc", bus_reqcyc, 1);
        sb.delete();
        zero_stop = 1'b0;
    endtask

    task automatic serve_req(input logic [63:0] exp_addr, input int delay);
        int w = 0;
        while (!bus_reqcyc && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("req_seen", bus_reqcyc, 1);
        check("req_addr", bus_req, exp_addr);
        check("req_tag", bus_reqtag, 13'h1100);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("req_hold_cyc", bus_reqcyc, 1);
            check("req_hold_addr", bus_req, exp_addr);
            check("req_hold_tag", bus_reqtag, 13'h1100);
        end
        bus_reqack = 1'b1;
        @(negedge clk);
        bus_reqack = 1'b0;
        check("req_single", bus_reqcyc, 0);
    endtask

    task automatic send_beats(input logic [63:0] line, input int first, input int cnt,
                              input logic [7:0] salt, input int start_slot, input bit push);
        for (int k = first; k < first + cnt; k++) begin
            int w = 0;
            bus_respcyc = 1'b1;
            bus_resp    = beat_data(line, k, salt);
            if (push) begin
                for (int h = 0; h < 2; h++) begin
                    int slot = 2 * k + h;
                    if (slot >= start_slot)
                        push_inst(line + 64'(4 * slot), inst_word(line + 64'(4 * slot), salt));
                end
            end
            #1;
            while (!bus_respack && w < 20) begin
                @(negedge clk);
                #1;
                w++;
            end
            check("beat_ack", bus_respack, 1);
            @(negedge clk);
        end
        bus_respcyc = 1'b0;
    endtask

    task automatic drain(input int n, input logic [63:0] stall_pc, input int stall_cycles);
        int          got = 0;
        int          cyc = 0;
        int          stall_left = stall_cycles;
        logic [63:0] hp = '0;
        logic [31:0] hd = '0;
        exp_t        e;
        while (got < n && cyc < 400) begin
            if (inst_valid && stall_left > 0 && inst_pc == stall_pc) begin
                if (stall_left == stall_cycles) begin
                    hp = inst_pc;
                    hd = inst_data;
                end else begin
                    check("stall_pc", inst_pc, hp);
                    check("stall_data", inst_data, hd);
                end
                inst_ready = 1'b0;
                stall_left--;
            end else begin
                inst_ready = 1'b1;
                if (inst_valid) begin
                    checks++;
                    assert (sb.size() > 0) else begin
                        errors++;
                        $error("FAIL sb_underflow: observed pc %h with empty queue, expected no instruction", inst_pc);
                    end
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("inst_pc", inst_pc, e.pc);
                        check("inst_data", inst_data, e.data);
                    end
                    got++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        check("drain_count", got, n);
        check("drain_cycles", cyc, n + stall_cycles);
        check("sb_left", sb.size(), 0);
    endtask

    initial begin
        reset       = 1'b1;
        entry       = '0;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        inst_ready  = 1'b0;

        // Aligned entry with a 3-cycle decoder stall at 0x108.
        do_reset(64'h100);
        serve_req(64'h100, 2);
        send_beats(64'h100, 0, 8, 8'h00, 0, 1'b1);
        drain(16, 64'h108, 3);
        serve_req(64'h140, 0);

        // Unaligned entry and a slow bus acknowledge.
        do_reset(64'h118);
        serve_req(64'h100, 10);
        send_beats(64'h100, 0, 8, 8'h00, 6, 1'b1);
        drain(10, '1, 0);
        serve_req(64'h140, 1);
        send_beats(64'h140, 0, 8, 8'h00, 0, 1'b1);
        drain(16, '1, 0);
        serve_req(64'h180, 0);

        // Zero instruction in slot 5.
        do_reset(64'h300);
        zero_addr = 64'h314;
        serve_req(64'h300, 0);
        send_beats(64'h300, 0, 8, 8'h00, 0, 1'b1);
`ifdef FETCH_HALT_ON_ZERO_EN
        drain(5, '1, 0);
        begin
            logic quiet_bad = 1'b0;
            @(negedge clk);
            check("halted", halted, 1);
            for (int i = 0; i < 20; i++) begin
                if (bus_reqcyc || inst_valid) quiet_bad = 1'b1;
                @(negedge clk);
            end
            check("halt_quiet", quiet_bad, 0);
            check("halt_sticky", halted, 1);
        end
`else
        drain(16, '1, 0);
        check("no_halt", halted, 0);
        serve_req(64'h340, 0);
`endif
        zero_addr = '1;

        // Reset after 4 of 8 beats: leftovers dropped, line refetched.
        do_reset(64'h200);
        serve_req(64'h200, 0);
        send_beats(64'h200, 0, 4, 8'h01, 0, 1'b0);
        do_reset(64'h200);
        send_beats(64'h200, 4, 4, 8'h01, 0, 1'b0);
        check("stale_no_valid", inst_valid, 0);
        serve_req(64'h200, 0);
        send_beats(64'h200, 0, 8, 8'h00, 0, 1'b1);
        drain(16, '1, 0);
        serve_req(64'h240, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
